// File: rtl/audio_i2s_tx.sv
// I2S transmitter for a 16-bit stereo DAC: derives mclk/sck/lrck from a free-running
// 9-bit counter and shifts one sample pair per 512-clk frame, MSB first, with the I2S one-bit delay.
module audio_i2s_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] audio_left,
    input  logic [15:0] audio_right,
    input  logic        in_valid,
    input  logic        mute,
    output logic        in_ready,
    output logic        mclk,
    output logic        sck,
    output logic        lrck,
    output logic        sdin,
    output logic        underrun
);

    logic [8:0]  r_cnt;
    logic [15:0] r_tx_left;
    logic [15:0] r_tx_right;
    logic        r_sdin;
    logic        r_in_ready;
    logic        r_underrun;

    logic [8:0]  w_cnt_next;
    logic [3:0]  w_slot;
    logic        w_half;
    logic [3:0]  w_bit_idx;
    logic        w_slot_start;
    logic        w_frame_end;
    logic        w_next_bit;

    always_comb begin
        w_cnt_next   = r_cnt + 9'd1;
        w_slot       = w_cnt_next[7:4];
        w_half       = w_cnt_next[8];
        // 16 - k modulo 16; slot 0 is handled separately below
        w_bit_idx    = 4'd0 - w_slot;
        w_slot_start = (r_cnt[3:0] == 4'hF);
        w_frame_end  = (r_cnt == 9'd511);
        w_next_bit   = 1'b0;
        if (w_slot == 4'd0) begin
            // Left slot 0 uses tx_right before this edge's load (non-blocking read).
            w_next_bit = w_half ? r_tx_left[0] : r_tx_right[0];
        end else begin
            w_next_bit = w_half ? r_tx_right[w_bit_idx] : r_tx_left[w_bit_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= 9'd0;
            r_tx_left  <= 16'd0;
            r_tx_right <= 16'd0;
            r_sdin     <= 1'b0;
            r_in_ready <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_in_ready <= (w_cnt_next == 9'd511);
            if (w_slot_start) begin
                r_sdin <= w_next_bit;
            end
            if (w_frame_end) begin
                if (mute) begin
                    r_tx_left  <= 16'd0;
                    r_tx_right <= 16'd0;
                end else if (in_valid) begin
                    r_tx_left  <= audio_left;
                    r_tx_right <= audio_right;
                end else begin
                    r_underrun <= 1'b1;
                end
            end
        end
    end

    assign mclk     = r_cnt[1];
    assign sck      = r_cnt[3];
    assign lrck     = r_cnt[8];
    assign sdin     = r_sdin;
    assign in_ready = r_in_ready;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboard bench for audio_i2s_tx: each accepted pair pushes its 32 expected slot bits,
// which are popped and compared slot by slot while clock phases and flags are checked every cycle.
module tb_audio_i2s_tx;

    logic        clk;
    logic        rst;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        in_valid;
    logic        mute;
    logic        in_ready;
    logic        mclk;
    logic        sck;
    logic        lrck;
    logic        sdin;
    logic        underrun;

    audio_i2s_tx dut (
        .clk         (clk),
        .rst         (rst),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .in_valid    (in_valid),
        .mute        (mute),
        .in_ready    (in_ready),
        .mclk        (mclk),
        .sck         (sck),
        .lrck        (lrck),
        .sdin        (sdin),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0]  tb_cnt;
    logic        sb[$];
    logic        cur_exp = 1'b0;
    logic [15:0] model_l = 16'd0;
    logic [15:0] model_r = 16'd0;
    logic        model_uf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference frame timing: time since reset release, in clk cycles mod 512.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cnt <= 9'd0;
        else     tb_cnt <= tb_cnt + 9'd1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("mclk", {31'd0, mclk}, {31'd0, tb_cnt[1]});
            chk("sck", {31'd0, sck}, {31'd0, tb_cnt[3]});
            chk("lrck", {31'd0, lrck}, {31'd0, tb_cnt[8]});
            chk("in_ready", {31'd0, in_ready}, {31'd0, (tb_cnt == 9'd511)});
            chk("underrun", {31'd0, underrun}, {31'd0, model_uf});
            if (tb_cnt[3:0] == 4'd1) begin
                if (sb.size() == 0) chk("sb_depth", 32'(sb.size()), 32'd1);
                else cur_exp = sb.pop_front();
            end
            if (tb_cnt[3:0] != 4'd0) chk("sdin", {31'd0, sdin}, {31'd0, cur_exp});
        end
    end

    // Apply the frame-boundary rules and queue the next frame's 32 slot bits.
    task automatic model_load(input logic v, input logic m, input logic [15:0] l, input logic [15:0] r);
        logic prev_r0;
        prev_r0 = model_r[0];
        if (m) begin
            model_l = 16'd0;
            model_r = 16'd0;
        end else if (v) begin
            model_l = l;
            model_r = r;
        end else begin
            model_uf <= 1'b1;
        end
        sb.push_back(prev_r0);
        for (int i = 15; i >= 1; i--) sb.push_back(model_l[i]);
        sb.push_back(model_l[0]);
        for (int i = 15; i >= 1; i--) sb.push_back(model_r[i]);
        $display("frame load: valid=%0b mute=%0b left=%h right=%h -> tx %h/%h", v, m, l, r, model_l, model_r);
    endtask

    task automatic push_zero_frame();
        for (int i = 0; i < 32; i++) sb.push_back(1'b0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mclk"}, {31'd0, mclk}, 32'd0);
        chk({tag, "_sck"}, {31'd0, sck}, 32'd0);
        chk({tag, "_lrck"}, {31'd0, lrck}, 32'd0);
        chk({tag, "_sdin"}, {31'd0, sdin}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_underrun"}, {31'd0, underrun}, 32'd0);
    endtask

    // Junk on the inputs mid-frame; the real pair is presented only for the cnt==511 cycle.
    task automatic send(input logic v, input logic m, input logic [15:0] l, input logic [15:0] r);
        do begin
            @(negedge clk);
            audio_left  = 16'($urandom);
            audio_right = 16'($urandom);
            in_valid    = 1'($urandom);
            mute        = 1'($urandom);
        end while (tb_cnt != 9'd510);
        in_valid    = v;
        mute        = m;
        audio_left  = l;
        audio_right = r;
        @(negedge clk);
        model_load(v, m, l, r);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        audio_left = 16'd0;
        audio_right = 16'd0;
        in_valid = 1'b0;
        mute = 1'b0;
        #1;
        chk_reset_outputs("por");
        repeat (3) @(negedge clk);
        push_zero_frame();
        #2 rst = 1'b0;

        send(1'b1, 1'b0, 16'hE000, 16'h2000);
        send(1'b1, 1'b0, 16'h0001, 16'h8001);
        send(1'b1, 1'b1, 16'h7FFF, 16'h7FFF);
        send(1'b0, 1'b1, 16'h7FFF, 16'h7FFF);
        send(1'b1, 1'b0, 16'h1234, 16'hABCD);
        send(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        send(1'b1, 1'b0, 16'($urandom), 16'($urandom));
        send(1'b1, 1'b0, 16'($urandom), 16'($urandom));

        // Mid-frame reset at cnt == 300.
        do @(negedge clk); while (tb_cnt != 9'd300);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        sb.delete();
        model_l = 16'd0;
        model_r = 16'd0;
        model_uf = 1'b0;
        cur_exp = 1'b0;
        push_zero_frame();
        in_valid = 1'b1;
        mute = 1'b0;
        audio_left = 16'hC3A5;
        audio_right = 16'h5A3C;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 600);
        chk("first_ready", 32'(n), 32'd511);
        model_load(1'b1, 1'b0, 16'hC3A5, 16'h5A3C);
        send(1'b1, 1'b0, 16'h8000, 16'h0001);

        n = 0;
        while (sb.size() > 0 && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
